board_ram: RTL and testbench
============================

Name: board_ram

Overview:
Parametrised word-addressed game-board RAM, memory-mapped at a configurable base address on the CPU data bus. Successor to the fixed 100-word board store. Adds:
- valid/ready request channel with a registered response channel;
- out-of-range and misalignment error reporting;
- a sequential clear engine that sweeps the array after reset or on request, instead of resetting every word in parallel.

Parameters:
DATA_W, 32, data word width in bits; multiple of 8.
DEPTH, 100, number of words.
BASE_ADDR, 32'h0000_1000, byte address of word 0.
ADDR_W, 32, bus address width.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  reset, asynchronous, active-high.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request.
req_write  in  1  1 = write, 0 = read.
req_addr  in  ADDR_W  byte address.
req_wdata  in  DATA_W  write data.
req_be  in  DATA_W/8  byte enables; present only with BOARD_RAM_BYTE_EN.
rsp_valid  out  1  one-cycle response pulse.
rsp_rdata  out  DATA_W  read data.
rsp_err  out  1  request was out of range or misaligned.
clear_start  in  1  request a full-array clear.
clear_busy  out  1  clear sweep in progress.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, clear_busy=1; FSM=CLEAR; clear counter=0.
- The memory array has no reset. Contents are defined only after a sweep completes.
- States:
  - CLEAR: writes 0 to word[cnt], then cnt++. After cnt reaches DEPTH-1 and that word is written, go to IDLE. Takes exactly DEPTH cycles after rst deassertion.
  - IDLE: accepts requests.
- req_ready = (state==IDLE). clear_busy = (state==CLEAR).
- Accept condition: req_valid && req_ready. No request is accepted in CLEAR.
- Address decode:
  - BYTES = DATA_W/8.
  - Request is in range iff BASE_ADDR <= addr < BASE_ADDR + BYTES*DEPTH, and addr mod BYTES == 0.
  - index = (addr - BASE_ADDR) >> $clog2(BYTES), width $clog2(DEPTH).
- Accepted write, in range: word updated on the same edge. Next cycle: rsp_valid=1, rsp_err=0, rsp_rdata=0.
- Accepted read, in range: next cycle rsp_valid=1, rsp_rdata=word[index], rsp_err=0. Latency is 1 cycle, full throughput of one request per cycle, no response backpressure.
- Out of range or misaligned:
  - No array access.
  - Next cycle: rsp_valid=1, rsp_err=1, rsp_rdata=0.
- rsp_valid and rsp_err are single-cycle pulses. rsp_rdata holds its value until the next response.
- A read in the cycle directly after a write to the same index returns the new data.
- clear_start in IDLE: go to CLEAR next cycle, cnt=0.
- clear_start and an accepted request in the same cycle: the request completes normally, with its response next cycle. The sweep then starts and overwrites any write.
- clear_start while in CLEAR: ignored; no restart.
- rst asserted mid-sweep or mid-request: immediate return to reset values. Any pending response is dropped. The sweep restarts from word 0.

Optional Feature:
- Macro: BOARD_RAM_BYTE_EN.
- Defined: req_be port exists. Writes update only the bytes whose enable bit is 1. A write with req_be=0 is still acknowledged (rsp_valid=1, rsp_err=0) and changes nothing. Reads ignore req_be.
- Undefined: port absent; every write updates the full word.

Decomposition:
- Package board_ram_pkg holds:
  - state enum board_ram_state_t {CLEAR, IDLE};
  - default constants BOARD_BASE_ADDR=32'h1000 and BOARD_DEPTH=100;
  - helper function for the in-range/alignment check.
- Sub-module board_ram_clear_seq owns the FSM and counter. It outputs clr_we, clr_idx and busy. The top level muxes its array-write port between clear and request.

Test Plan:
- Reset release: deassert rst -> clear_busy=1 and req_ready=0 for exactly 100 cycles, then req_ready=1. A read of 0x1000 then returns 0x0.
- Write 0xDEADBEEF to 0x118C, then read 0x118C on the next cycle -> rsp_rdata=0xDEADBEEF, rsp_err=0, 1-cycle latency.
- Read 0x1190, read 0x0FFC and write 0x1002 -> each gives rsp_err=1, rsp_rdata=0. A following read of 0x1000 shows it unchanged.
- Write 0x12345678 to 0x1010, then clear_start -> 100-cycle busy window with req_ready=0. A read of 0x1010 afterwards returns 0x0.
- Assert rst at sweep cycle 40 -> outputs return to reset values, then a full 100-cycle sweep follows.
- With BOARD_RAM_BYTE_EN: write 0xFFFFFFFF with be=4'hF, then write 0x000000AA with be=4'h1 -> read returns 0xFFFFFFAA.

Source files
------------

// File: rtl/board_ram_pkg.sv
// board_ram_pkg: shared types, default constants and the address check
// used by the board RAM. The optional byte-enable build is controlled by
// the BOARD_RAM_BYTE_EN macro in board_ram.sv, not here.
package board_ram_pkg;

  // Sweep-then-serve controller states.
  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } board_ram_state_t;

  localparam logic [31:0] BOARD_BASE_ADDR = 32'h0000_1000;
  localparam int          BOARD_DEPTH     = 100;

  // True when addr falls inside [base, base + bytes*depth) and is aligned to
  // a whole word. Arguments are widened to 64 bits by the caller so that
  // base + size cannot wrap for any realistic bus width.
  function automatic logic board_addr_ok(
    input logic [63:0] addr,
    input logic [63:0] base,
    input int unsigned bytes,
    input int unsigned depth
  );
    logic [63:0] limit;
    logic [63:0] bytes_w;
    bytes_w = 64'(bytes);
    limit   = base + (bytes_w * 64'(depth));
    return (addr >= base) && (addr < limit) && ((addr % bytes_w) == 64'd0);
  endfunction

endpackage

// File: rtl/board_ram_clear_seq.sv
// board_ram_clear_seq: controller that sweeps zeros through the whole array
// after reset or on request, then hands the array over to the bus.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   clear_start   request a new sweep (honoured only while idle)
//   clr_we        array write strobe for the sweep
//   clr_idx       word index being cleared
//   busy          high for the whole sweep (exactly DEPTH cycles)
module board_ram_clear_seq
  import board_ram_pkg::*;
#(
  parameter int DEPTH = BOARD_DEPTH,
  parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_start,
  output logic             clr_we,
  output logic [IDX_W-1:0] clr_idx,
  output logic             busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  board_ram_state_t state_r;
  board_ram_state_t state_s;
  logic [IDX_W-1:0] cnt_r;
  logic [IDX_W-1:0] cnt_s;

  // Next-state and counter logic; a clear request during a sweep is ignored.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      CLEAR: begin
        if (cnt_r == LAST_IDX) begin
          state_s = IDLE;
          cnt_s   = {IDX_W{1'b0}};
        end else begin
          state_s = CLEAR;
          cnt_s   = cnt_r + IDX_W'(1);
        end
      end
      IDLE: begin
        if (clear_start) begin
          state_s = CLEAR;
          cnt_s   = {IDX_W{1'b0}};
        end else begin
          state_s = IDLE;
          cnt_s   = cnt_r;
        end
      end
      default: begin
        state_s = CLEAR;
        cnt_s   = {IDX_W{1'b0}};
      end
    endcase
  end

  // State and counter registers; reset always restarts the sweep at word 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= CLEAR;
      cnt_r   <= {IDX_W{1'b0}};
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  assign busy    = (state_r == CLEAR);
  assign clr_we  = (state_r == CLEAR);
  assign clr_idx = cnt_r;

endmodule

// File: rtl/board_ram.sv
// board_ram: word-addressed game-board RAM mapped at BASE_ADDR on the CPU
// data bus, with a valid/ready request channel and a one-cycle registered
// response. The array is not reset; a zero sweep runs after reset and on
// clear_start.
// Optional feature: define BOARD_RAM_BYTE_EN to add the req_be port and
// per-byte write enables; otherwise every write updates the full word.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid/req_ready       request handshake (ready only when idle)
//   req_write, req_addr       1 = write; byte address
//   req_wdata, req_be         write data; byte enables (BOARD_RAM_BYTE_EN)
//   rsp_valid, rsp_rdata      response pulse; read data (held between responses)
//   rsp_err                   out-of-range or misaligned request
//   clear_start, clear_busy   start a sweep; sweep in progress
module board_ram
  import board_ram_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = BOARD_DEPTH,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BOARD_BASE_ADDR)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
`ifdef BOARD_RAM_BYTE_EN
  input  logic [DATA_W/8-1:0] req_be,
`endif
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  input  logic                clear_start,
  output logic                clear_busy
);

  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SHIFT = (BYTES > 1) ? $clog2(BYTES) : 0;

  logic [DATA_W-1:0] mem_r [DEPTH];

  logic              clr_we_s;
  logic [IDX_W-1:0]  clr_idx_s;
  logic              accept_s;
  logic              in_range_s;
  logic [ADDR_W-1:0] offset_s;
  logic [IDX_W-1:0]  req_idx_s;
  logic              wr_en_s;
  logic [IDX_W-1:0]  wr_idx_s;
  logic [DATA_W-1:0] wr_data_s;
  logic [DATA_W-1:0] wr_mask_s;

  board_ram_clear_seq #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_clear_seq (
    .clk         (clk),
    .rst         (rst),
    .clear_start (clear_start),
    .clr_we      (clr_we_s),
    .clr_idx     (clr_idx_s),
    .busy        (clear_busy)
  );

  assign req_ready  = ~clear_busy;
  assign accept_s   = req_valid && req_ready;
  assign in_range_s = board_addr_ok(64'(req_addr), 64'(BASE_ADDR), BYTES, DEPTH);
  assign offset_s   = req_addr - BASE_ADDR;
  assign req_idx_s  = IDX_W'(offset_s >> SHIFT);

  // Single array write port shared by the sweep and bus writes. They never
  // collide because requests are refused while the sweep runs.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_idx_s  = clr_idx_s;
    wr_data_s = {DATA_W{1'b0}};
    wr_mask_s = {DATA_W{1'b0}};
    if (clr_we_s) begin
      wr_en_s   = 1'b1;
      wr_idx_s  = clr_idx_s;
      wr_data_s = {DATA_W{1'b0}};
      wr_mask_s = {DATA_W{1'b1}};
    end else if (accept_s && req_write && in_range_s) begin
      wr_en_s   = 1'b1;
      wr_idx_s  = req_idx_s;
      wr_data_s = req_wdata;
`ifdef BOARD_RAM_BYTE_EN
      for (int b = 0; b < BYTES; b++) begin
        wr_mask_s[b*8 +: 8] = {8{req_be[b]}};
      end
`else
      wr_mask_s = {DATA_W{1'b1}};
`endif
    end else begin
      wr_en_s   = 1'b0;
      wr_idx_s  = clr_idx_s;
      wr_data_s = {DATA_W{1'b0}};
      wr_mask_s = {DATA_W{1'b0}};
    end
  end

  // Array storage (no reset); masked merge gives byte-granular writes.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_idx_s] <= (mem_r[wr_idx_s] & ~wr_mask_s) | (wr_data_s & wr_mask_s);
    end
  end

  // Registered response. A read issued right after a write to the same word
  // sees the new value because the write lands on the accepting edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= {DATA_W{1'b0}};
    end else begin
      rsp_valid <= accept_s;
      rsp_err   <= accept_s && !in_range_s;
      if (accept_s) begin
        if (in_range_s && !req_write) begin
          rsp_rdata <= mem_r[req_idx_s];
        end else begin
          rsp_rdata <= {DATA_W{1'b0}};
        end
      end
    end
  end

endmodule

// File: tb/tb_board_ram.sv
// tb_board_ram: directed plus randomized self-checking bench for board_ram
// (default parameters: 32-bit words, 100 words at byte address 0x1000).
// Expected values come from a word-array model of the memory map.
module tb_board_ram;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
`ifdef BOARD_RAM_BYTE_EN
  logic [3:0]  req_be;
`endif
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        clear_start;
  logic        clear_busy;

  int          n_vec;
  int          n_err;
  logic [31:0] model [100];
  logic [31:0] last_rdata;

  board_ram #(
    .DATA_W    (32),
    .DEPTH     (100),
    .ADDR_W    (32),
    .BASE_ADDR (32'h0000_1000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
`ifdef BOARD_RAM_BYTE_EN
    .req_be      (req_be),
`endif
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .clear_start (clear_start),
    .clear_busy  (clear_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 100; i++) model[i] = 32'h0;
  endtask

  // One request, applied for one edge, response checked 1 time unit later.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, input logic clr);
    logic        ok;
    int          idx;
    logic [31:0] exp_d;
    logic [3:0]  eff_be;
`ifdef BOARD_RAM_BYTE_EN
    eff_be = be;
`else
    eff_be = be | 4'hF;
`endif
    req_valid   = 1'b1;
    req_write   = wr;
    req_addr    = addr;
    req_wdata   = wd;
`ifdef BOARD_RAM_BYTE_EN
    req_be      = be;
`endif
    clear_start = clr;
    ok  = (addr >= 32'h1000) && (addr < 32'h1000 + 32'd400) && (addr % 32'd4 == 32'd0);
    idx = ok ? int'((addr - 32'h1000) / 32'd4) : 0;
    exp_d = 32'h0;
    if (ok && wr) begin
      for (int b = 0; b < 4; b++)
        if (eff_be[b]) model[idx][b*8 +: 8] = wd[b*8 +: 8];
    end else if (ok) begin
      exp_d = model[idx];
    end
    @(posedge clk); #1;
    req_valid   = 1'b0;
    clear_start = 1'b0;
    check("rsp_valid", {31'h0, rsp_valid}, 32'h1);
    check("rsp_err",   {31'h0, rsp_err},   {31'h0, ~ok});
    check("rsp_rdata", rsp_rdata, exp_d);
    last_rdata = exp_d;
  endtask

  // Cycles with no request: no response pulse, read data held.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check("idle_valid", {31'h0, rsp_valid}, 32'h0);
      check("idle_err",   {31'h0, rsp_err},   32'h0);
      check("idle_rdata", rsp_rdata, last_rdata);
    end
  endtask

  // Called just after the sweep began; counts edges until it ends. A
  // clear_start pulse is injected at poke_at to show it cannot restart.
  task automatic wait_sweep(input int poke_at);
    int cnt;
    cnt = 0;
    check("busy_start", {31'h0, clear_busy}, 32'h1);
    while (clear_busy && cnt < 400) begin
      check("ready_in_clear", {31'h0, req_ready}, 32'h0);
      clear_start = (cnt == poke_at);
      req_valid   = (cnt == poke_at);
      @(posedge clk); #1;
      cnt++;
    end
    clear_start = 1'b0;
    req_valid   = 1'b0;
    check("sweep_cycles", 32'(cnt), 32'd100);
    check("ready_after",  {31'h0, req_ready}, 32'h1);
    check("no_rsp_sweep", {31'h0, rsp_valid}, 32'h0);
    model_clear();
  endtask

  task automatic check_reset_vals();
    check("rst_ready", {31'h0, req_ready},  32'h0);
    check("rst_valid", {31'h0, rsp_valid},  32'h0);
    check("rst_rdata", rsp_rdata,           32'h0);
    check("rst_err",   {31'h0, rsp_err},    32'h0);
    check("rst_busy",  {31'h0, clear_busy}, 32'h1);
  endtask

  initial begin
    logic [31:0] a;
    int          sel;
    n_vec = 0; n_err = 0; last_rdata = 32'h0;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0;
    req_wdata = 32'h0; clear_start = 1'b0;
`ifdef BOARD_RAM_BYTE_EN
    req_be = 4'h0;
`endif
    #3;
    check_reset_vals();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    wait_sweep(-1);

    // Post-reset contents and the top word of the array.
    issue(1'b0, 32'h1000, 32'h0, 4'hF, 1'b0);
    issue(1'b1, 32'h118C, 32'hDEADBEEF, 4'hF, 1'b0);
    issue(1'b0, 32'h118C, 32'h0, 4'hF, 1'b0);
    check("deadbeef", rsp_rdata, 32'hDEADBEEF);
    idle(2);

    // Just past the end, just below the base, misaligned write.
    issue(1'b0, 32'h1190, 32'h0, 4'hF, 1'b0);
    issue(1'b0, 32'h0FFC, 32'h0, 4'hF, 1'b0);
    issue(1'b1, 32'h1002, 32'hCAFEF00D, 4'hF, 1'b0);
    issue(1'b0, 32'h1000, 32'h0, 4'hF, 1'b0);
    check("base_unchanged", rsp_rdata, 32'h0);

    // Requested clear, with a stray clear_start mid-sweep.
    issue(1'b1, 32'h1010, 32'h12345678, 4'hF, 1'b0);
    issue(1'b0, 32'h1010, 32'h0, 4'hF, 1'b0);
    clear_start = 1'b1;
    @(posedge clk); #1;
    clear_start = 1'b0;
    idle(0);
    wait_sweep(50);
    issue(1'b0, 32'h1010, 32'h0, 4'hF, 1'b0);
    check("cleared_1010", rsp_rdata, 32'h0);

    // Write accepted in the same cycle as clear_start: acked, then wiped.
    issue(1'b1, 32'h1020, 32'h55AA55AA, 4'hF, 1'b1);
    wait_sweep(-1);
    issue(1'b0, 32'h1020, 32'h0, 4'hF, 1'b0);

    // Reset at sweep cycle 40, and a fresh full sweep afterwards.
    issue(1'b1, 32'h1030, 32'h0BADF00D, 4'hF, 1'b0);
    issue(1'b0, 32'h1030, 32'h0, 4'hF, 1'b0);
    clear_start = 1'b1;
    @(posedge clk); #1;
    clear_start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_vals();
    last_rdata = 32'h0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    wait_sweep(-1);

    // Reset with a read response on the output drops it.
    issue(1'b1, 32'h1040, 32'h600DCAFE, 4'hF, 1'b0);
    issue(1'b0, 32'h1040, 32'h0, 4'hF, 1'b0);
    rst = 1'b1;
    #1;
    check_reset_vals();
    last_rdata = 32'h0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    wait_sweep(-1);

`ifdef BOARD_RAM_BYTE_EN
    issue(1'b1, 32'h1050, 32'hFFFFFFFF, 4'hF, 1'b0);
    issue(1'b1, 32'h1050, 32'h000000AA, 4'h1, 1'b0);
    issue(1'b0, 32'h1050, 32'h0, 4'h0, 1'b0);
    check("byte_en", rsp_rdata, 32'hFFFFFFAA);
    issue(1'b1, 32'h1050, 32'h12345678, 4'h0, 1'b0);
    issue(1'b0, 32'h1050, 32'h0, 4'h0, 1'b0);
    check("be_zero", rsp_rdata, 32'hFFFFFFAA);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        idle(1);
      end else begin
        sel = int'($urandom_range(0, 9));
        if (sel < 7)
          a = 32'h1000 + 32'd4 * $urandom_range(0, 99);
        else if (sel == 7)
          a = 32'h1000 + 32'd4 * $urandom_range(0, 99) + $urandom_range(1, 3);
        else if (sel == 8)
          a = 32'h1190 + $urandom_range(0, 63);
        else
          a = 32'h1000 - $urandom_range(1, 64);
        issue(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), 1'b0);
      end
    end
    idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
